eeprom_rw_test: RTL and testbench

- Command sequencer that sits directly upstream of the IIC byte driver and drives its exec/addr/data request interface.
- On a start pulse it writes a known pattern to BYTE_NUM consecutive EEPROM addresses, waiting the EEPROM write-cycle time after each byte. It then reads every byte back and compares it.
- It reports pass/fail, the first failing address and the NACK cause.
- It is clocked by the driver's divided clock, so the request/done handshake is same-domain.

---
 rtl/eeprom_test_pkg.sv | 26 ++
 rtl/eeprom_rw_test.sv | 215 +++++++++++++++++++++
 tb/tb_eeprom_rw_test.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_test_pkg.sv
// Shared definitions for the EEPROM write/read-back sequencer: one-hot state
// encodings, error codes and the test-pattern helper.
package eeprom_test_pkg;

  typedef enum logic [7:0] {
    IDLE    = 8'b0000_0001,
    WR_REQ  = 8'b0000_0010,
    WR_WAIT = 8'b0000_0100,
    WR_GAP  = 8'b0000_1000,
    RD_REQ  = 8'b0001_0000,
    RD_WAIT = 8'b0010_0000,
    CHECK   = 8'b0100_0000,
    FINISH  = 8'b1000_0000
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_DATA = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  function automatic logic [7:0] pattern_byte(input logic [15:0] idx,
                                               input logic [7:0]  seed);
    return idx[7:0] ^ seed;
  endfunction

endpackage

// File: rtl/eeprom_rw_test.sv
// Writes a seeded pattern to BYTE_NUM consecutive EEPROM addresses through the
// IIC byte driver, reads every byte back, and reports pass/fail with cause.
module eeprom_rw_test
  import eeprom_test_pkg::*;
#(
  parameter logic [15:0] BYTE_NUM    = 16'd256,
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic        ADDR16      = 1'b1,
  parameter logic [7:0]  SEED        = 8'h5A,
  parameter logic [15:0] WR_WAIT_MAX = 16'd5000,
  parameter logic [15:0] TIMEOUT_MAX = 16'd2000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic        iic_exec,
  output logic        iic_bit_ctrl,
  output logic        iic_rh_wl,
  output logic [15:0] iic_addr,
  output logic [7:0]  iic_data_w,
  input  logic [7:0]  iic_data_r,
  input  logic        iic_done,
  input  logic        iic_ack,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  err_code,
  output logic [15:0] err_addr
);

  state_e      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_w_q, data_w_d;
  logic        rh_wl_q, rh_wl_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] err_addr_q, err_addr_d;

  logic [15:0] nxt_idx;
  logic [15:0] cnt_inc;
  logic        last_byte;
  logic        err_hit;
  logic [1:0]  err_sel;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      index_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_w_q   <= '0;
      rh_wl_q    <= 1'b0;
      rd_byte_q  <= '0;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_w_q   <= data_w_d;
      rh_wl_q    <= rh_wl_d;
      rd_byte_q  <= rd_byte_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_w_d   = data_w_q;
    rh_wl_d    = rh_wl_q;
    rd_byte_d  = rd_byte_q;
    busy_d     = busy_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    err_hit    = 1'b0;
    err_sel    = ERR_NONE;
    nxt_idx    = index_q + 16'd1;
    cnt_inc    = cnt_q + 16'd1;
    last_byte  = (index_q == BYTE_NUM - 16'd1);

    // Request fields are loaded on entry to a *_REQ state so they are already
    // stable in the exec cycle and stay put until the matching done.
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          err_code_d = ERR_NONE;
          err_addr_d = '0;
          index_d    = '0;
          busy_d     = 1'b1;
          addr_d     = START_ADDR;
          data_w_d   = pattern_byte(16'd0, SEED);
          rh_wl_d    = 1'b0;
          state_d    = WR_REQ;
        end
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (iic_done) begin
          if (iic_ack) begin
            err_hit = 1'b1;
            err_sel = ERR_NACK;
          end else begin
            cnt_d   = '0;
            state_d = WR_GAP;
          end
        end else if (cnt_inc == TIMEOUT_MAX - 16'd1) begin
          // Lands the failure exactly TIMEOUT_MAX cycles after the exec pulse.
          err_hit = 1'b1;
          err_sel = ERR_TOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR_GAP: begin
        if (cnt_q == WR_WAIT_MAX - 16'd1) begin
          if (last_byte) begin
            index_d = '0;
            addr_d  = START_ADDR;
            rh_wl_d = 1'b1;
            state_d = RD_REQ;
          end else begin
            index_d  = nxt_idx;
            addr_d   = START_ADDR + nxt_idx;
            data_w_d = pattern_byte(nxt_idx, SEED);
            rh_wl_d  = 1'b0;
            state_d  = WR_REQ;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_REQ: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (iic_done) begin
          if (iic_ack) begin
            err_hit = 1'b1;
            err_sel = ERR_NACK;
          end else begin
            rd_byte_d = iic_data_r;
            state_d   = CHECK;
          end
        end else if (cnt_inc == TIMEOUT_MAX - 16'd1) begin
          err_hit = 1'b1;
          err_sel = ERR_TOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CHECK: begin
        if (rd_byte_q != pattern_byte(index_q, SEED)) begin
          err_hit = 1'b1;
          err_sel = ERR_DATA;
        end else if (last_byte) begin
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          index_d = nxt_idx;
          addr_d  = START_ADDR + nxt_idx;
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every error path aborts the run at the address currently on the bus.
    if (err_hit) begin
      fail_d     = 1'b1;
      pass_d     = 1'b0;
      busy_d     = 1'b0;
      err_code_d = err_sel;
      err_addr_d = addr_q;
      state_d    = FINISH;
    end
  end

  assign iic_exec     = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign iic_bit_ctrl = ADDR16;
  assign iic_rh_wl    = rh_wl_q;
  assign iic_addr     = addr_q;
  assign iic_data_w   = data_w_q;
  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign err_code     = err_code_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_eeprom_rw_test.sv
// Directed bench for eeprom_rw_test: two instances (normal window and a
// window wrapping past 0xFFFF) each served by a small behavioural EEPROM.
module tb_eeprom_rw_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A signals
  logic        exec_a, bit_a, rh_a, busy_a, pass_a, fail_a;
  logic [15:0] addr_a, ea_a;
  logic [7:0]  dw_a;
  logic [1:0]  ec_a;
  logic [7:0]  dr_a = 8'h00;
  logic        done_a = 1'b0;
  logic        ack_a = 1'b0;

  // Instance B signals
  logic        exec_b, bit_b, rh_b, busy_b, pass_b, fail_b;
  logic [15:0] addr_b, ea_b;
  logic [7:0]  dw_b;
  logic [1:0]  ec_b;
  logic [7:0]  dr_b = 8'h00;
  logic        done_b = 1'b0;
  logic        ack_b = 1'b0;

  eeprom_rw_test #(
    .BYTE_NUM(16'd4), .START_ADDR(16'h0010), .ADDR16(1'b1), .SEED(8'h5A),
    .WR_WAIT_MAX(16'd10), .TIMEOUT_MAX(16'd50)
  ) dut_a (
    .sys_clk(clk), .sys_rst(rst), .start(start_a), .iic_exec(exec_a),
    .iic_bit_ctrl(bit_a), .iic_rh_wl(rh_a), .iic_addr(addr_a),
    .iic_data_w(dw_a), .iic_data_r(dr_a), .iic_done(done_a), .iic_ack(ack_a),
    .busy(busy_a), .pass(pass_a), .fail(fail_a), .err_code(ec_a),
    .err_addr(ea_a)
  );

  eeprom_rw_test #(
    .BYTE_NUM(16'd2), .START_ADDR(16'hFFFF), .ADDR16(1'b1), .SEED(8'h5A),
    .WR_WAIT_MAX(16'd10), .TIMEOUT_MAX(16'd50)
  ) dut_b (
    .sys_clk(clk), .sys_rst(rst), .start(start_b), .iic_exec(exec_b),
    .iic_bit_ctrl(bit_b), .iic_rh_wl(rh_b), .iic_addr(addr_b),
    .iic_data_w(dw_b), .iic_data_r(dr_b), .iic_done(done_b), .iic_ack(ack_b),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .err_code(ec_b),
    .err_addr(ea_b)
  );

  // Behavioural EEPROM for A with fault injection; logs every request.
  logic [7:0]  mem_a [0:65535];
  bit          hang = 1'b0, corrupt_en = 1'b0, nack_en = 1'b0;
  logic [15:0] corrupt_addr = 16'h0000, nack_addr = 16'h0000;
  bit          pend_a = 1'b0, have_wr_a = 1'b0;
  int          lat_a = 0, cyc_a = 0, last_wr_a = 0;
  logic [15:0] cur_addr_a = 16'h0000;
  logic        cur_rh_a = 1'b0;
  logic [15:0] log_addr_a [$];
  logic        log_rh_a [$];
  logic [7:0]  log_data_a [$];
  int          gap_a [$];

  always @(posedge clk) begin
    cyc_a  <= cyc_a + 1;
    done_a <= 1'b0;
    ack_a  <= 1'b0;
    if (rst) begin
      pend_a    <= 1'b0;
      have_wr_a <= 1'b0;
    end else begin
      if (done_a && !cur_rh_a) begin
        last_wr_a <= cyc_a;
        have_wr_a <= 1'b1;
      end
      if (exec_a) begin
        pend_a     <= 1'b1;
        lat_a      <= 3;
        cur_addr_a <= addr_a;
        cur_rh_a   <= rh_a;
        log_addr_a.push_back(addr_a);
        log_rh_a.push_back(rh_a);
        log_data_a.push_back(dw_a);
        if (have_wr_a) begin
          gap_a.push_back(cyc_a - last_wr_a - 1);
          have_wr_a <= 1'b0;
        end
        if (!rh_a) mem_a[addr_a] <= dw_a;
      end else if (pend_a) begin
        if (lat_a == 1) begin
          pend_a <= 1'b0;
          if (!hang) begin
            done_a <= 1'b1;
            ack_a  <= nack_en && !cur_rh_a && (cur_addr_a == nack_addr);
            dr_a   <= (corrupt_en && cur_rh_a && cur_addr_a == corrupt_addr) ?
                      8'h00 : mem_a[cur_addr_a];
          end
        end else begin
          lat_a <= lat_a - 1;
        end
      end
    end
  end

  // Fault-free EEPROM for B.
  logic [7:0]  mem_b [0:65535];
  bit          pend_b = 1'b0;
  int          lat_b = 0;
  logic [15:0] cur_addr_b = 16'h0000;
  logic [15:0] log_addr_b [$];
  logic        log_rh_b [$];
  logic [7:0]  log_data_b [$];

  always @(posedge clk) begin
    done_b <= 1'b0;
    ack_b  <= 1'b0;
    if (rst) begin
      pend_b <= 1'b0;
    end else if (exec_b) begin
      pend_b     <= 1'b1;
      lat_b      <= 2;
      cur_addr_b <= addr_b;
      log_addr_b.push_back(addr_b);
      log_rh_b.push_back(rh_b);
      log_data_b.push_back(dw_b);
      if (!rh_b) mem_b[addr_b] <= dw_b;
    end else if (pend_b) begin
      if (lat_b == 1) begin
        pend_b <= 1'b0;
        done_b <= 1'b1;
        dr_b   <= mem_b[cur_addr_b];
      end else begin
        lat_b <= lat_b - 1;
      end
    end
  end

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy_a) begin
        expired = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (exec_a !== 1'b0) begin fails++; $display("FAIL rst_exec: got %b want 0", exec_a); end
    tests++; if (bit_a !== 1'b1) begin fails++; $display("FAIL rst_bit_ctrl: got %b want 1", bit_a); end
    tests++; if ({busy_a, pass_a, fail_a, rh_a} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b want 0000", {busy_a, pass_a, fail_a, rh_a}); end
    tests++; if ({ec_a, ea_a, addr_a, dw_a} !== 42'd0) begin fails++; $display("FAIL rst_fields: ec=%h ea=%h addr=%h dw=%h want all 0", ec_a, ea_a, addr_a, dw_a); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_run();
    int base, gbase, n;
    bit to;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h5A; exp_d[1] = 8'h5B; exp_d[2] = 8'h58; exp_d[3] = 8'h59;
    base = log_addr_a.size(); gbase = gap_a.size();
    pulse_start_a();
    wait_idle_a(2000, to);
    tests++; if (to) begin fails++; $display("FAIL pass_busy_timeout: busy=%b want 0", busy_a); end
    n = log_addr_a.size() - base;
    tests++; if (n != 8) begin fails++; $display("FAIL pass_exec_count: got %0d want 8", n); end
    if (n == 8) begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (log_addr_a[base+i] !== 16'h0010 + 16'(i % 4) || log_rh_a[base+i] !== (i >= 4)) begin
          fails++; $display("FAIL pass_req%0d: addr=%h rh=%b want addr=%h rh=%b", i,
            log_addr_a[base+i], log_rh_a[base+i], 16'h0010 + 16'(i % 4), (i >= 4));
        end
        if (i < 4) begin
          tests++;
          if (log_data_a[base+i] !== exp_d[i]) begin
            fails++; $display("FAIL pass_wdata%0d: got %h want %h", i, log_data_a[base+i], exp_d[i]);
          end
        end
      end
    end
    tests++; if ({pass_a, fail_a, ec_a} !== 4'b1000) begin fails++; $display("FAIL pass_result: pass=%b fail=%b ec=%0d want 1 0 0", pass_a, fail_a, ec_a); end
    tests++; if (gap_a.size() - gbase != 4) begin fails++; $display("FAIL pass_gap_count: got %0d want 4", gap_a.size() - gbase); end
    for (int g = gbase; g < gap_a.size(); g++) begin
      tests++; if (gap_a[g] < 10) begin fails++; $display("FAIL pass_gap%0d: got %0d idle cycles want >=10", g - gbase, gap_a[g]); end
    end
  endtask

  task automatic test_data_mismatch();
    int base, n, rd13;
    bit to;
    corrupt_en = 1'b1; corrupt_addr = 16'h0012;
    base = log_addr_a.size();
    pulse_start_a();
    wait_idle_a(2000, to);
    tests++; if (to) begin fails++; $display("FAIL mism_busy_timeout: busy=%b want 0", busy_a); end
    tests++; if ({pass_a, fail_a, ec_a} !== 4'b0110) begin fails++; $display("FAIL mism_result: pass=%b fail=%b ec=%0d want 0 1 2", pass_a, fail_a, ec_a); end
    tests++; if (ea_a !== 16'h0012) begin fails++; $display("FAIL mism_err_addr: got %h want 0012", ea_a); end
    n = log_addr_a.size() - base;
    rd13 = 0;
    for (int i = base; i < log_addr_a.size(); i++)
      if (log_rh_a[i] && log_addr_a[i] == 16'h0013) rd13++;
    tests++; if (n != 7 || rd13 != 0) begin fails++; $display("FAIL mism_requests: got %0d execs, %0d reads of 0013 want 7, 0", n, rd13); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_nack();
    int base;
    bit to;
    nack_en = 1'b1; nack_addr = 16'h0011;
    base = log_addr_a.size();
    pulse_start_a();
    wait_idle_a(2000, to);
    repeat (20) @(negedge clk);
    tests++; if (to) begin fails++; $display("FAIL nack_busy_timeout: busy=%b want 0", busy_a); end
    tests++; if ({pass_a, fail_a, ec_a} !== 4'b0101) begin fails++; $display("FAIL nack_result: pass=%b fail=%b ec=%0d want 0 1 1", pass_a, fail_a, ec_a); end
    tests++; if (ea_a !== 16'h0011) begin fails++; $display("FAIL nack_err_addr: got %h want 0011", ea_a); end
    tests++; if (log_addr_a.size() - base != 2) begin fails++; $display("FAIL nack_exec_count: got %0d want 2", log_addr_a.size() - base); end
    nack_en = 1'b0;
  endtask

  task automatic test_timeout();
    int k, lag;
    hang = 1'b1;
    pulse_start_a();
    k = 0;
    while (!exec_a && k < 20) begin @(negedge clk); k++; end
    tests++; if (!exec_a) begin fails++; $display("FAIL tout_no_exec: exec=%b want 1", exec_a); end
    lag = 0;
    while (!fail_a && lag < 200) begin @(negedge clk); lag++; end
    tests++; if (lag != 50) begin fails++; $display("FAIL tout_latency: fail after %0d cycles want 50", lag); end
    tests++; if ({pass_a, fail_a, ec_a, busy_a} !== 5'b01110) begin fails++; $display("FAIL tout_result: pass=%b fail=%b ec=%0d busy=%b want 0 1 3 0", pass_a, fail_a, ec_a, busy_a); end
    tests++; if (ea_a !== 16'h0010) begin fails++; $display("FAIL tout_err_addr: got %h want 0010", ea_a); end
    hang = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    pulse_start_a();
    tests++; if (exec_a !== 1'b1) begin fails++; $display("FAIL rmid_exec_before: got %b want 1", exec_a); end
    #2 rst = 1'b1;
    #1;
    tests++; if (exec_a !== 1'b0) begin fails++; $display("FAIL rmid_exec_low: got %b want 0", exec_a); end
    tests++; if ({busy_a, pass_a, fail_a, rh_a, ec_a, ea_a, addr_a, dw_a} !== 46'd0) begin
      fails++; $display("FAIL rmid_outputs: busy=%b pass=%b fail=%b rh=%b ec=%h ea=%h addr=%h dw=%h want all 0",
        busy_a, pass_a, fail_a, rh_a, ec_a, ea_a, addr_a, dw_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = log_addr_a.size();
    pulse_start_a();
    wait_idle_a(2000, to);
    tests++; if (to || pass_a !== 1'b1 || fail_a !== 1'b0) begin fails++; $display("FAIL rmid_rerun: expired=%b pass=%b fail=%b want 0 1 0", to, pass_a, fail_a); end
    tests++; if (log_addr_a.size() - base != 8) begin fails++; $display("FAIL rmid_exec_count: got %0d want 8", log_addr_a.size() - base); end
  endtask

  task automatic test_start_while_busy();
    int base;
    bit to;
    base = log_addr_a.size();
    pulse_start_a();
    repeat (15) @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_mid_run: got %b want 1", busy_a); end
    pulse_start_a();
    wait_idle_a(2000, to);
    tests++; if (to || pass_a !== 1'b1) begin fails++; $display("FAIL busy_run_result: expired=%b pass=%b want 0 1", to, pass_a); end
    tests++; if (log_addr_a.size() - base != 8) begin fails++; $display("FAIL busy_exec_count: got %0d want 8", log_addr_a.size() - base); end
  endtask

  task automatic test_addr_wrap();
    int base, n, k;
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFF; exp_addr[1] = 16'h0000;
    exp_addr[2] = 16'hFFFF; exp_addr[3] = 16'h0000;
    base = log_addr_b.size();
    pulse_start_b();
    k = 0;
    while (busy_b && k < 2000) begin @(negedge clk); k++; end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL wrap_busy_timeout: busy=%b want 0", busy_b); end
    n = log_addr_b.size() - base;
    tests++; if (n != 4) begin fails++; $display("FAIL wrap_exec_count: got %0d want 4", n); end
    if (n == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (log_addr_b[base+i] !== exp_addr[i] || log_rh_b[base+i] !== (i >= 2)) begin
          fails++; $display("FAIL wrap_req%0d: addr=%h rh=%b want addr=%h rh=%b", i,
            log_addr_b[base+i], log_rh_b[base+i], exp_addr[i], (i >= 2));
        end
      end
      tests++; if (log_data_b[base] !== 8'h5A || log_data_b[base+1] !== 8'h5B) begin
        fails++; $display("FAIL wrap_wdata: got %h %h want 5a 5b", log_data_b[base], log_data_b[base+1]);
      end
    end
    tests++; if ({pass_b, fail_b, ec_b} !== 4'b1000) begin fails++; $display("FAIL wrap_result: pass=%b fail=%b ec=%0d want 1 0 0", pass_b, fail_b, ec_b); end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_data_mismatch();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_start_while_busy();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
